// File: rtl/spi_ram_ctrl.sv
// Command sequencer turning 10-bit SPI frames into single-port RAM cycles.
// Optional build macro SPI_RAM_AUTO_INC_EN: post-increment wr_addr/rd_addr on each WRITE/READ.
module spi_ram_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [9:0]            rx_data,
  input  logic                  rx_valid,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  input  logic [7:0]            mem_rdata,
  output logic                  busy,
  output logic                  drop_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    RD_WAIT = 2'd2
  } state_t;

  localparam logic [1:0] OP_SET_WADDR = 2'b00;
  localparam logic [1:0] OP_WRITE     = 2'b01;
  localparam logic [1:0] OP_SET_RADDR = 2'b10;
  localparam logic [1:0] LAT_INIT     = RD_LATENCY[1:0];

  state_t                  state;
  logic                    rx_valid_q;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic [1:0]              lat_cnt;
  logic                    accept;
  logic [1:0]              opcode;
  logic [7:0]              payload;

  // A level held high on rx_valid counts as a single frame.
  assign accept  = rx_valid & ~rx_valid_q;
  assign opcode  = rx_data[9:8];
  assign payload = rx_data[7:0];
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rx_valid_q <= 1'b0;
      wr_addr    <= '0;
      rd_addr    <= '0;
      lat_cnt    <= 2'd0;
      tx_data    <= 8'd0;
      tx_valid   <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 8'd0;
      drop_err   <= 1'b0;
    end else begin
      rx_valid_q <= rx_valid;
      tx_valid   <= 1'b0;

      if (accept && state != IDLE) begin
        drop_err <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            case (opcode)
              OP_SET_WADDR: wr_addr <= payload[ADDR_WIDTH-1:0];
              OP_WRITE: begin
                mem_en    <= 1'b1;
                mem_we    <= 1'b1;
                mem_addr  <= wr_addr;
                mem_wdata <= payload;
                state     <= WRITE;
`ifdef SPI_RAM_AUTO_INC_EN
                wr_addr   <= wr_addr + 1'b1;
`endif
              end
              OP_SET_RADDR: rd_addr <= payload[ADDR_WIDTH-1:0];
              default: begin
                mem_en   <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= rd_addr;
                lat_cnt  <= LAT_INIT;
                state    <= RD_WAIT;
`ifdef SPI_RAM_AUTO_INC_EN
                rd_addr  <= rd_addr + 1'b1;
`endif
              end
            endcase
          end
        end
        WRITE: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          state  <= IDLE;
        end
        RD_WAIT: begin
          mem_en <= 1'b0;
          // Capture one edge after the counter has run down to zero.
          if (lat_cnt == 2'd0) begin
            tx_data  <= mem_rdata;
            tx_valid <= 1'b1;
            state    <= IDLE;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Bench for spi_ram_ctrl: two instances (8-bit addr / latency 1, 4-bit addr / latency 3)
// share one frame stream and are compared against a transaction-level model.
module tb_spi_ram_ctrl;

  logic       clk;
  logic       rst_n;
  logic [9:0] rx_data;
  logic       rx_valid;

  logic [7:0] tx_data   [2];
  logic       tx_valid  [2];
  logic       mem_en    [2];
  logic       mem_we    [2];
  logic [7:0] maddr     [2];
  logic [7:0] mem_wdata [2];
  logic [7:0] mem_rdata [2];
  logic       busy      [2];
  logic       drop_err  [2];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int aw_of(input int i);
    return (i == 0) ? 8 : 4;
  endfunction

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      localparam int AW = (gi == 0) ? 8 : 4;
      localparam int L  = (gi == 0) ? 1 : 3;
      logic [AW-1:0] addr_w;
      logic [7:0]    mem  [256];
      bit            vld  [256];
      logic [7:0]    pipe [3];

      assign maddr[gi]     = 8'(addr_w);
      assign mem_rdata[gi] = pipe[L-1];

      spi_ram_ctrl #(.ADDR_WIDTH(AW), .RD_LATENCY(L)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data[gi]),
        .tx_valid  (tx_valid[gi]),
        .mem_en    (mem_en[gi]),
        .mem_we    (mem_we[gi]),
        .mem_addr  (addr_w),
        .mem_wdata (mem_wdata[gi]),
        .mem_rdata (mem_rdata[gi]),
        .busy      (busy[gi]),
        .drop_err  (drop_err[gi])
      );

      // RAM: unwritten locations read back as addr ^ 0xC3; read data pipelined L deep.
      always @(posedge clk) begin
        if (mem_en[gi] && mem_we[gi]) begin
          mem[addr_w] <= mem_wdata[gi];
          vld[addr_w] <= 1'b1;
        end
        if (mem_en[gi] && !mem_we[gi]) begin
          pipe[0] <= vld[addr_w] ? mem[addr_w] : (8'(addr_w) ^ 8'hC3);
        end
        for (int s = 1; s < 3; s++) pipe[s] <= pipe[s-1];
      end
    end
  endgenerate

  // Event monitor: counts and last values of RAM writes, tx pulses and busy cycles.
  int         wr_cnt [2];
  int         wr_cyc [2];
  logic [7:0] wr_a   [2];
  logic [7:0] wr_d   [2];
  int         tx_cnt [2];
  int         tx_cyc [2];
  logic [7:0] tx_d   [2];
  int         bz_cnt [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      wr_cnt[i] = 0; tx_cnt[i] = 0; bz_cnt[i] = 0;
      wr_cyc[i] = 0; tx_cyc[i] = 0;
      wr_a[i] = 8'd0; wr_d[i] = 8'd0; tx_d[i] = 8'd0;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (mem_en[i] === 1'b1 && mem_we[i] === 1'b1) begin
        wr_cnt[i] <= wr_cnt[i] + 1;
        wr_cyc[i] <= cyc;
        wr_a[i]   <= maddr[i];
        wr_d[i]   <= mem_wdata[i];
      end
      if (tx_valid[i] === 1'b1) begin
        tx_cnt[i] <= tx_cnt[i] + 1;
        tx_cyc[i] <= cyc;
        tx_d[i]   <= tx_data[i];
      end
      if (busy[i] === 1'b1) bz_cnt[i] <= bz_cnt[i] + 1;
    end
  end

  // Reference model state.
  int         m_wa   [2];
  int         m_ra   [2];
  bit         m_drop [2];
  logic [7:0] m_tx   [2];
  logic [7:0] m_mem  [2][256];
  bit         m_vld  [2][256];

  function automatic logic [7:0] m_read(input int i, input int a);
    return m_vld[i][a] ? m_mem[i][a] : (8'(a) ^ 8'hC3);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_wa[i] = 0; m_ra[i] = 0; m_drop[i] = 1'b0; m_tx[i] = 8'd0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s u%0d tx_data", tag, i), 32'(tx_data[i]), 0);
      chk($sformatf("%s u%0d tx_valid", tag, i), 32'(tx_valid[i]), 0);
      chk($sformatf("%s u%0d mem_en", tag, i), 32'(mem_en[i]), 0);
      chk($sformatf("%s u%0d mem_we", tag, i), 32'(mem_we[i]), 0);
      chk($sformatf("%s u%0d mem_addr", tag, i), 32'(maddr[i]), 0);
      chk($sformatf("%s u%0d mem_wdata", tag, i), 32'(mem_wdata[i]), 0);
      chk($sformatf("%s u%0d busy", tag, i), 32'(busy[i]), 0);
      chk($sformatf("%s u%0d drop_err", tag, i), 32'(drop_err[i]), 0);
    end
  endtask

  // Apply one frame (called at a negedge with both instances idle), optionally
  // followed by a second frame edge while the first operation is still busy.
  task automatic send(input logic [9:0] f, input int hold, input bit intrude);
    int k;
    int s_wr [2];
    int s_tx [2];
    int s_bz [2];
    int op, p, mask, ea, e_wr, e_tx, e_bz;
    for (int i = 0; i < 2; i++) begin
      s_wr[i] = wr_cnt[i]; s_tx[i] = tx_cnt[i]; s_bz[i] = bz_cnt[i];
    end
    rx_data  = f;
    rx_valid = 1'b1;
    k = cyc + 1;
    repeat (hold) @(negedge clk);
    rx_valid = 1'b0;
    if (intrude) begin
      @(negedge clk);
      rx_data  = 10'h1EE;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
    end
    repeat (6) @(negedge clk);

    op = int'(f[9:8]);
    p  = int'(f[7:0]);
    for (int i = 0; i < 2; i++) begin
      mask = (1 << aw_of(i)) - 1;
      e_wr = 0; e_tx = 0; e_bz = 0; ea = 0;
      case (op)
        0: m_wa[i] = p & mask;
        1: begin
          e_wr = 1; e_bz = 1; ea = m_wa[i];
          m_mem[i][ea] = 8'(p);
          m_vld[i][ea] = 1'b1;
`ifdef SPI_RAM_AUTO_INC_EN
          m_wa[i] = (m_wa[i] + 1) & mask;
`endif
        end
        2: m_ra[i] = p & mask;
        default: begin
          e_tx = 1; e_bz = lat_of(i) + 1;
          m_tx[i] = m_read(i, m_ra[i]);
`ifdef SPI_RAM_AUTO_INC_EN
          m_ra[i] = (m_ra[i] + 1) & mask;
`endif
        end
      endcase
      if (intrude) m_drop[i] = 1'b1;

      chk($sformatf("u%0d f=%03h write count", i, f), 32'(wr_cnt[i] - s_wr[i]), 32'(e_wr));
      if (e_wr != 0) begin
        chk($sformatf("u%0d f=%03h write cycle", i, f), 32'(wr_cyc[i]), 32'(k));
        chk($sformatf("u%0d f=%03h write addr", i, f), 32'(wr_a[i]), 32'(ea));
        chk($sformatf("u%0d f=%03h write data", i, f), 32'(wr_d[i]), 32'(p));
      end
      chk($sformatf("u%0d f=%03h tx count", i, f), 32'(tx_cnt[i] - s_tx[i]), 32'(e_tx));
      if (e_tx != 0) begin
        chk($sformatf("u%0d f=%03h tx cycle", i, f), 32'(tx_cyc[i]), 32'(k + lat_of(i) + 1));
        chk($sformatf("u%0d f=%03h tx byte", i, f), 32'(tx_d[i]), 32'(m_tx[i]));
      end
      chk($sformatf("u%0d f=%03h busy cycles", i, f), 32'(bz_cnt[i] - s_bz[i]), 32'(e_bz));
      chk($sformatf("u%0d f=%03h drop_err", i, f), 32'(drop_err[i]), 32'(m_drop[i]));
      chk($sformatf("u%0d f=%03h tx_data hold", i, f), 32'(tx_data[i]), 32'(m_tx[i]));
      chk($sformatf("u%0d f=%03h mem_en idle", i, f), 32'(mem_en[i]), 0);
    end
    $display("frame %03h hold=%0d intrude=%0d accepted at edge %0d", f, hold, intrude, k);
  endtask

  initial begin
    int s_tx [2];
    int s_bz [2];
    logic [9:0] f;
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 10'd0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Basic write, then write and read back through a separate read address.
    send(10'h012, 1, 1'b0);
    send(10'h1A5, 1, 1'b0);
    send(10'h012, 1, 1'b0);
    send(10'h13C, 1, 1'b0);
    send(10'h212, 1, 1'b0);
    send(10'h300, 1, 1'b0);

    // Level held high for five cycles is a single frame.
    send(10'h1FF, 5, 1'b0);

    // Address wrap on increment (auto-inc build) or hold (default build).
    send(10'h0FF, 1, 1'b0);
    send(10'h111, 1, 1'b0);
    send(10'h122, 1, 1'b0);
    send(10'h2FF, 2, 1'b0);
    send(10'h300, 1, 1'b0);
    send(10'h300, 1, 1'b0);

    for (int n = 0; n < 40; n++) begin
      f = 10'($urandom);
      send(f, int'($urandom_range(1, 3)), 1'b0);
    end

    // Frame edge during a read: dropped, the read still completes once.
    send(10'h3A0, 1, 1'b1);
    send(10'h055, 1, 1'b0);

    // Reset one cycle after a READ is accepted: read abandoned.
    for (int i = 0; i < 2; i++) begin
      s_tx[i] = tx_cnt[i]; s_bz[i] = bz_cnt[i];
    end
    rx_data  = 10'h300;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rst_n    = 1'b0;
    model_reset();
    @(negedge clk);
    check_reset_values("midread_rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("midread u%0d tx count", i), 32'(tx_cnt[i] - s_tx[i]), 0);
      chk($sformatf("midread u%0d busy cycles", i), 32'(bz_cnt[i] - s_bz[i]), 1);
    end
    check_reset_values("after_rst");
    $display("reset applied mid-read, released at edge %0d", cyc);

    // READ right after reset uses rd_addr 0.
    send(10'h3FF, 1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
